rr_x_in_arbiter: RTL



---
 rtl/rr_x_in_arbiter_pkg.sv | 26 ++
 rtl/rr_x_in_fpa.sv | 22 ++
 rtl/rr_x_in_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/rr_x_in_arbiter_pkg.sv
// Shared definitions for the X_IN round-robin arbiter: size defaults, state encoding
// and the one-hot to binary helper used for grant_idx.
package rr_x_in_arbiter_pkg;

  localparam int unsigned IO_SIZE_DEFAULT = 5;
  localparam int unsigned IO_W_DEFAULT    = 3;

  localparam logic IDLE    = 1'b0;
  localparam logic GRANTED = 1'b1;

  typedef enum logic {
    StIdle    = IDLE,
    StGranted = GRANTED
  } state_e;

  // OR-ing the indices of set bits is exact for one-hot input and yields 0 for all-zero.
  function automatic int unsigned onehot_to_bin(input logic [31:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (onehot[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_x_in_fpa.sv
// Combinational fixed-priority picker: the lowest set index of req_i wins.
module rr_x_in_fpa #(
  parameter int unsigned Width = 5
) (
  input  logic [0:Width-1] req_i,
  output logic [0:Width-1] gnt_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int unsigned j = 0; j < Width; j++) begin
      if (req_i[j] && !found) begin
        gnt_o[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_x_in_arbiter.sv
// Round-robin arbiter for the router X_IN port with a registered one-hot grant.
// Define RR_X_IN_LOCK_EN to hold a grant while the granted requester keeps requesting.
module rr_x_in_arbiter
  import rr_x_in_arbiter_pkg::*;
#(
  parameter int unsigned IO_SIZE = IO_SIZE_DEFAULT,
  parameter int unsigned IO_w    = IO_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [0:IO_SIZE-1] request,
  input  logic               update,
  output logic [0:IO_SIZE-1] grant,
  output logic               grant_valid,
  output logic [IO_w-1:0]    grant_idx
);

  logic [0:IO_SIZE-1] mask;
  logic [0:IO_SIZE-1] req_masked;
  logic [0:IO_SIZE-1] gnt_masked;
  logic [0:IO_SIZE-1] gnt_raw;
  logic [0:IO_SIZE-1] arb_grant;
  logic [0:IO_SIZE-1] grant_d, grant_q;
  logic [IO_w-1:0]    idx_d, idx_q;
  logic [IO_w-1:0]    ptr_d, ptr_q;
  logic [31:0]        grant_oh;
  state_e             state_d, state_q;

  // Requesters at or above the pointer get first pick.
  always_comb begin
    mask = '0;
    for (int unsigned j = 0; j < IO_SIZE; j++) begin
      mask[j] = (IO_w'(j) >= ptr_q);
    end
  end

  assign req_masked = request & mask;

  rr_x_in_fpa #(
    .Width (IO_SIZE)
  ) u_fpa_masked (
    .req_i (req_masked),
    .gnt_o (gnt_masked)
  );

  rr_x_in_fpa #(
    .Width (IO_SIZE)
  ) u_fpa_raw (
    .req_i (request),
    .gnt_o (gnt_raw)
  );

  assign arb_grant = (|req_masked) ? gnt_masked : gnt_raw;

  always_comb begin
    grant_d = arb_grant;
`ifdef RR_X_IN_LOCK_EN
    // Packet lock: keep the current owner while its request line stays high.
    if ((state_q == StGranted) && (|(grant_q & request))) begin
      grant_d = grant_q;
    end
`endif

    state_d = state_q;
    unique case (state_q)
      StIdle:    if (|request) state_d = StGranted;
      StGranted: if (!(|grant_d)) state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    grant_oh = '0;
    for (int unsigned j = 0; j < IO_SIZE; j++) begin
      grant_oh[j] = grant_d[j];
    end
    idx_d = IO_w'(onehot_to_bin(grant_oh));

    // Rotation keys off the grant currently presented, not the one being loaded.
    ptr_d = ptr_q;
    if (update && (state_q == StGranted)) begin
      ptr_d = (idx_q == IO_w'(IO_SIZE - 1)) ? '0 : idx_q + IO_w'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = (state_q == StGranted);
  assign grant_idx   = idx_q;

endmodule
